mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction-fetch port, the data port and the
// shared memory, as seen by mem_arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  logic        pipeline_stall;
  logic        err;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output m_req, m_we, m_addr, m_wdata, pipeline_stall, err
  );

  // Requester / memory-model side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, pipeline_stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one shared memory port.
// Data accesses win by default; a fetch that has waited behind STARVE_MAX
// consecutive data grants is served next.
// Optional feature macro: MEM_ARBITER_TIMEOUT_EN -- aborts an access that
// sees no m_ack within TIMEOUT_CYC busy cycles, returning 32'hDEADBEEF and
// pulsing err. Without it the arbiter waits forever and err is tied low.
module mem_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  // Elaboration-time guard on parameter ranges.
  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       grant_d;
  logic       grant_if;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
`else
  assign bus.err = 1'b0;
`endif

  // Arbitration decision, only acted upon while IDLE.
  always_comb begin
    grant_d  = bus.d_req && (!bus.if_req || (starve_cnt < STARVE_LIM));
    grant_if = bus.if_req && !grant_d;
  end

  assign bus.pipeline_stall = (bus.if_req && !bus.if_ready) ||
                              (bus.d_req && !bus.d_ready);

  // Main FSM: grant, drive the memory request, complete or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.if_ready <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_ready  <= 1'b0;
      bus.d_rdata  <= '0;
      starve_cnt   <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      bus.err      <= 1'b0;
      tcnt         <= '0;
`endif
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      bus.err      <= 1'b0;
`endif

      // Starvation counter runs only while a fetch is actually waiting.
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (state == IDLE && grant_if) begin
        starve_cnt <= '0;
      end else if (state == IDLE && grant_d && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          // m_ack here belongs to no access and is ignored.
          if (grant_d) begin
            state       <= BUSY_D;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
          end else if (grant_if) begin
            state       <= BUSY_IF;
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= bus.if_addr;
            bus.m_wdata <= '0;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          tcnt <= '0;
`endif
        end

        BUSY_IF, BUSY_D: begin
          if (bus.m_ack) begin
            state     <= IDLE;
            bus.m_req <= 1'b0;
            bus.m_we  <= 1'b0;
            if (state == BUSY_IF) begin
              bus.if_rdata <= bus.m_rdata;
              bus.if_ready <= 1'b1;
            end else begin
              bus.d_rdata <= bus.m_rdata;
              bus.d_ready <= 1'b1;
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            tcnt <= '0;
          end else if (tcnt == TLIM) begin
            state     <= IDLE;
            bus.m_req <= 1'b0;
            bus.m_we  <= 1'b0;
            bus.err   <= 1'b1;
            tcnt      <= '0;
            if (state == BUSY_IF) begin
              bus.if_rdata <= 32'hDEADBEEF;
              bus.if_ready <= 1'b1;
            end else begin
              bus.d_rdata <= 32'hDEADBEEF;
              bus.d_ready <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          bus.m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data transactions, starvation
// ordering, mid-access reset and the busy-wait / timeout behaviour.
module tb_mem_arbiter;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  txn_t sb[$];
  logic [31:0] ord[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction: drive request, watch grant, ack after busy_wait
  // extra busy cycles, check the ready pulse and returned data.
  task automatic run_txn(input bit port, input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int busy_wait);
    txn_t t;
    int   n;
    if (port) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    sb.push_back('{port, addr, we, wdata, rdata});
    #1;
    check("stall_on_req", bus.pipeline_stall, 1'b1);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.m_req && n < 8);
    t = sb.pop_front();
    check("grant_latency", n, 1);
    check("m_req_busy", bus.m_req, 1'b1);
    check("m_addr", bus.m_addr, t.addr);
    check("m_we", bus.m_we, t.we);
    if (t.we) check("m_wdata", bus.m_wdata, t.wdata);
    for (int i = 0; i < busy_wait; i++) begin
      if (t.port) begin
        bus.d_addr = ~t.addr; bus.d_wdata = ~t.wdata; bus.d_we = ~t.we;
      end else begin
        bus.if_addr = ~t.addr;
      end
      cycle();
      check("m_req_held", bus.m_req, 1'b1);
      check("m_addr_held", bus.m_addr, t.addr);
      check("m_we_held", bus.m_we, t.we);
    end
    check("stall_busy", bus.pipeline_stall, 1'b1);
    bus.m_ack = 1'b1;
    bus.m_rdata = t.rdata;
    cycle();
    bus.m_ack = 1'b0;
    bus.m_rdata = 32'h0;
    check("m_req_drop", bus.m_req, 1'b0);
    if (t.port) begin
      check("d_ready", bus.d_ready, 1'b1);
      check("if_ready_quiet", bus.if_ready, 1'b0);
      if (!t.we) check("d_rdata", bus.d_rdata, t.rdata);
      bus.d_req = 1'b0;
    end else begin
      check("if_ready", bus.if_ready, 1'b1);
      check("d_ready_quiet", bus.d_ready, 1'b0);
      check("if_rdata", bus.if_rdata, t.rdata);
      check("stall_at_ready", bus.pipeline_stall, 1'b0);
      bus.if_req = 1'b0;
    end
    cycle();
    check("ready_one_pulse", bus.if_ready | bus.d_ready, 1'b0);
    check("idle_after", bus.m_req, 1'b0);
  endtask

  initial begin
    int n;
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_m_req", bus.m_req, 1'b0);
    check("rst_m_we", bus.m_we, 1'b0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_if_ready", bus.if_ready, 1'b0);
    check("rst_d_ready", bus.d_ready, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_err", bus.err, 1'b0);
    check("rst_stall", bus.pipeline_stall, 1'b0);
    reset = 1'b0;
    cycle();

    // m_ack while idle with no requests
    bus.m_ack = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    cycle();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    check("idle_ack_m_req", bus.m_req, 1'b0);
    check("idle_ack_ready", bus.if_ready | bus.d_ready, 1'b0);
    check("idle_ack_if_rdata", bus.if_rdata, 32'h0);
    check("idle_ack_d_rdata", bus.d_rdata, 32'h0);
    cycle();

    // Fetch with immediate ack
    run_txn(1'b0, 32'h100, 1'b0, 32'h0, 32'h00500093, 0);
    // Data write acked in the third busy cycle
    run_txn(1'b1, 32'h40, 1'b1, 32'hCAFEF00D, 32'h0, 2);
    check("if_rdata_hold_w", bus.if_rdata, 32'h00500093);
    // Data read
    run_txn(1'b1, 32'h44, 1'b0, 32'h0, 32'h11223344, 1);
    check("if_rdata_hold_r", bus.if_rdata, 32'h00500093);
    // Another fetch; data rdata must stay
    run_txn(1'b0, 32'h104, 1'b0, 32'h0, 32'h00A00113, 3);
    check("d_rdata_hold", bus.d_rdata, 32'h11223344);

    // Starvation: both requesting continuously, memory acks immediately
    ord = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    bus.if_addr = 32'h200; bus.if_req = 1'b1;
    bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_req = 1'b1;
    for (int c = 0; c < 30 && ord.size() > 0; c++) begin
      cycle();
      if (bus.m_req) check("grant_order", bus.m_addr, ord.pop_front());
    end
    check("grant_order_done", ord.size(), 0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    cycle();
    bus.m_ack = 1'b0;
    check("starve_drain", bus.m_req, 1'b0);
    cycle();
    check("starve_idle", bus.m_req, 1'b0);

    // Reset in the middle of a data access
    bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_we = 1'b0;
    cycle();
    check("mid_busy", bus.m_req, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_m_req", bus.m_req, 1'b0);
    check("mid_rst_d_ready", bus.d_ready, 1'b0);
    check("mid_rst_m_addr", bus.m_addr, 32'h0);
    check("mid_rst_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    check("mid_rst_no_ready", bus.d_ready, 1'b0);
    reset = 1'b0;
    cycle();
    check("regrant_m_req", bus.m_req, 1'b1);
    check("regrant_m_addr", bus.m_addr, 32'h80);
    bus.m_ack = 1'b1; bus.m_rdata = 32'h5A5A_A5A5;
    cycle();
    bus.m_ack = 1'b0;
    check("regrant_d_ready", bus.d_ready, 1'b1);
    check("regrant_d_rdata", bus.d_rdata, 32'h5A5A_A5A5);
    bus.d_req = 1'b0;
    cycle();

    // Memory never acknowledges
    bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_we = 1'b0;
    cycle();
    check("to_busy", bus.m_req, 1'b1);
`ifdef MEM_ARBITER_TIMEOUT_EN
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.d_ready && n < 40);
    check("to_cycles", n, 16);
    check("to_d_ready", bus.d_ready, 1'b1);
    check("to_err", bus.err, 1'b1);
    check("to_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    check("to_m_req", bus.m_req, 1'b0);
    bus.d_req = 1'b0;
    cycle();
    check("to_err_pulse", bus.err, 1'b0);
`else
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.m_req && !bus.err && !bus.d_ready) n++;
    end
    check("wait_cycles", n, 20);
    check("wait_m_req", bus.m_req, 1'b1);
    check("wait_err", bus.err, 1'b0);
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0BAD_F00D;
    cycle();
    bus.m_ack = 1'b0;
    check("wait_d_ready", bus.d_ready, 1'b1);
    check("wait_d_rdata", bus.d_rdata, 32'h0BAD_F00D);
    bus.d_req = 1'b0;
    cycle();
`endif
    check("final_idle", bus.m_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
